// File: rtl/mem_mux.sv
// mem_mux: streams a burst of SRAM lines (one bank per address) into a
// 2-entry output FIFO and presents them as byte-enabled beats toward DDR.
module mem_mux #(
  parameter int NUM_BANKS = 16,
  parameter int LINE_W    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [18:0]                       base_addr,
  input  logic [4:0]                        num_lines,
  input  logic [4:0]                        num_of_last_valid,
  output logic                              busy,
  output logic [NUM_BANKS-1:0]              sram_read,
  output logic [18:0]                       sram_addr,
  input  logic [NUM_BANKS-1:0][LINE_W-1:0]  sram_data,
  output logic [LINE_W-1:0]                 data_out,
  output logic [LINE_W/8-1:0]               byte_en,
  output logic                              data_valid,
  output logic                              data_last,
  input  logic                              data_ready,
  output logic                              done
);

  localparam int NB = LINE_W / 8;
  localparam int BW = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [18:0]        addr_q;
  logic [4:0]         lines_q, last_q, rd_cnt, beat_cnt;
  logic               infl, infl_last;
  logic [BW-1:0]      infl_bank;
  logic [LINE_W-1:0]  fifo_data [2];
  logic               fifo_last [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic [2:0]         occ;
  logic               issue, push, pop;
  logic [18:0]        rd_addr;
  logic [5:0]         v;
  logic [NB-1:0]      last_mask;
  logic [LINE_W-1:0]  push_data;

  // Read scheduling, FIFO handshake and final-beat byte mask.
  always_comb begin
    rd_addr    = addr_q + 19'(rd_cnt);
    data_valid = !rst && (count != 2'd0);
    pop        = data_valid && data_ready;
    push       = infl;
    // Occupancy counts the beat leaving this cycle so the stream can run at
    // one beat per cycle while still never exceeding two entries.
    occ        = 3'(count) + 3'(infl) - 3'(pop);
    issue      = !rst && (state == RUN) && (rd_cnt < lines_q) && (occ < 3'd2);
    v          = (last_q == 5'd0) ? 6'd32 : {1'b0, last_q};
    last_mask  = '0;
    push_data  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      last_mask[i]        = (i < 32'(v));
      push_data[i*8 +: 8] = (infl_last && !last_mask[i]) ? 8'h00
                                                         : sram_data[infl_bank][i*8 +: 8];
    end
  end

  // Next-state logic and externally visible outputs.
  always_comb begin
    state_nxt = state;
    busy      = !rst && (state != IDLE);
    done      = !rst && (state == DONE);
    sram_read = issue ? (NUM_BANKS'(1) << rd_addr[BW-1:0]) : '0;
    sram_addr = issue ? rd_addr : '0;
    data_out  = data_valid ? fifo_data[rd_ptr] : '0;
    data_last = data_valid && fifo_last[rd_ptr];
    byte_en   = data_valid ? (fifo_last[rd_ptr] ? last_mask : '1) : '0;
    case (state)
      IDLE: if (start) state_nxt = (num_lines == 5'd0) ? DONE : RUN;
      RUN:  if (pop && (beat_cnt == lines_q - 5'd1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Burst parameters, read/beat counters, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      lines_q   <= '0;
      last_q    <= '0;
      rd_cnt    <= '0;
      beat_cnt  <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      infl_bank <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_q   <= base_addr;
        lines_q  <= num_lines;
        last_q   <= num_of_last_valid;
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end
      if (issue) rd_cnt <= rd_cnt + 5'd1;
      if (pop)   beat_cnt <= beat_cnt + 5'd1;
      infl      <= issue;
      infl_last <= (rd_cnt == lines_q - 5'd1);
      infl_bank <= rd_addr[BW-1:0];
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage; contents are only observed through the occupancy gate.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= infl_last;
    end
  end

endmodule

// File: tb/tb_mem_mux.sv
// tb_mem_mux: directed and randomized bursts against a line-level reference
// model; SRAM banks are modelled as registered reads of a hashed address.
module tb_mem_mux;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [18:0]          base_addr = '0;
  logic [4:0]           num_lines = '0;
  logic [4:0]           num_of_last_valid = '0;
  logic                 busy;
  logic [15:0]          sram_read;
  logic [18:0]          sram_addr;
  logic [15:0][255:0]   sram_data = '0;
  logic [255:0]         data_out;
  logic [31:0]          byte_en;
  logic                 data_valid;
  logic                 data_last;
  logic                 data_ready = 1'b1;
  logic                 done;

  int errors = 0;
  int checks = 0;

  mem_mux #(.NUM_BANKS(16), .LINE_W(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .num_of_last_valid(num_of_last_valid),
    .busy(busy), .sram_read(sram_read), .sram_addr(sram_addr),
    .sram_data(sram_data), .data_out(data_out), .byte_en(byte_en),
    .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [18:0] a);
    logic [31:0] w;
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      w = 32'(a) * 32'h9E3779B1 + 32'(j) * 32'h7F4A7C15;
      w = w ^ (w >> 13) ^ 32'h5A5A0000;
      r[j*32 +: 32] = w;
    end
    return r;
  endfunction

  // Banks answer one cycle after their strobe; idle banks carry noise.
  always @(posedge clk) begin
    for (int b = 0; b < 16; b++)
      sram_data[b] <= sram_read[b] ? line_of(sram_addr) : {8{$urandom}};
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string p);
    check({p, "_busy"}, 256'(busy), 256'(0));
    check({p, "_done"}, 256'(done), 256'(0));
    check({p, "_valid"}, 256'(data_valid), 256'(0));
    check({p, "_last"}, 256'(data_last), 256'(0));
    check({p, "_sram_read"}, 256'(sram_read), 256'(0));
    check({p, "_sram_addr"}, 256'(sram_addr), 256'(0));
    check({p, "_data_out"}, data_out, 256'(0));
    check({p, "_byte_en"}, 256'(byte_en), 256'(0));
  endtask

  // mode 0: ready held high, 1: ready toggles 1,0,1,0, 2: random ready.
  task automatic run_burst(input logic [18:0] b, input int n, input logic [4:0] lv,
                           input int mode, input int abort_after, input bit spurious);
    logic [18:0]  ea[$];
    logic [255:0] ed[$];
    logic [31:0]  eb[$];
    logic [18:0]  a;
    logic [31:0]  be;
    logic [255:0] d, pd;
    logic [31:0]  pbe;
    logic         pl;
    int vbytes, reads, beats, cyc;
    bit prev_hold, done_exp, done_next, fin;
    vbytes = (lv == 5'd0) ? 32 : int'(lv);
    for (int k = 0; k < n; k++) begin
      a  = b + 19'(k);
      be = (k == n - 1) ? 32'((33'd1 << vbytes) - 33'd1) : 32'hFFFF_FFFF;
      d  = line_of(a);
      for (int i = 0; i < 32; i++) if (!be[i]) d[i*8 +: 8] = 8'h00;
      ea.push_back(a);
      ed.push_back(d);
      eb.push_back(be);
    end
    reads = 0; beats = 0; cyc = 0;
    prev_hold = 0; done_next = (n == 0); fin = 0;
    pd = '0; pbe = '0; pl = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_lines = 5'(n); num_of_last_valid = lv; data_ready = 1'b1;
    #1;
    check("idle_busy", 256'(busy), 256'(0));

    while (!fin) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (spurious && cyc == 3) begin
        start = 1'b1; base_addr = 19'h55555; num_lines = 5'd7; num_of_last_valid = 5'd3;
      end
      if (abort_after >= 0 && beats == abort_after) begin
        rst = 1'b1;
        #1;
        check_quiet("in_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_quiet("post_rst");
        repeat (6) begin
          @(posedge clk); #1; #1;
          check("abort_done", 256'(done), 256'(0));
          check("abort_valid", 256'(data_valid), 256'(0));
          check("abort_busy", 256'(busy), 256'(0));
        end
        return;
      end
      case (mode)
        0: data_ready = 1'b1;
        1: data_ready = (cyc % 2 == 0);
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
      #1;

      done_exp  = done_next;
      done_next = 0;
      check("busy", 256'(busy), 256'(1));
      check("done", 256'(done), 256'(done_exp));

      if (sram_read != 16'd0) begin
        check("read_in_range", 256'(reads < n), 256'(1));
        if (reads < n) begin
          check("rd_addr", 256'(sram_addr), 256'(ea[reads]));
          check("rd_bank", 256'(sram_read), 256'(16'd1 << ea[reads][3:0]));
        end
        reads++;
      end

      if (mode == 0 && n > 0)
        check("valid_timing", 256'(data_valid), 256'(cyc >= 2 && cyc - 2 < n));

      if (data_valid) begin
        if (prev_hold) begin
          check("hold_data", data_out, pd);
          check("hold_be", 256'(byte_en), 256'(pbe));
          check("hold_last", 256'(data_last), 256'(pl));
        end
        check("beat_in_range", 256'(beats < n), 256'(1));
        if (beats < n) begin
          check("data_out", data_out, ed[beats]);
          check("byte_en", 256'(byte_en), 256'(eb[beats]));
          check("data_last", 256'(data_last), 256'(beats == n - 1));
        end
        if (data_ready) begin
          beats++;
          if (beats == n) done_next = 1;
        end
      end
      prev_hold = data_valid && !data_ready;
      pd = data_out; pbe = byte_en; pl = data_last;

      check("occupancy", 256'((reads - beats) <= 2), 256'(1));

      if (done_exp) begin
        check("done_beats", 256'(beats), 256'(n));
        @(posedge clk); #1; #1;
        check("after_done_busy", 256'(busy), 256'(0));
        check("after_done_done", 256'(done), 256'(0));
        fin = 1;
      end
      cyc++;
      if (!fin && cyc > 300) begin
        check("timeout", 256'(0), 256'(1));
        fin = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; #1;
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_quiet("idle");

    run_burst(19'h00010, 4, 5'd0, 0, -1, 0);
    run_burst(19'h0001E, 3, 5'd5, 0, -1, 0);
    run_burst(19'h00123, 16, 5'd17, 1, -1, 0);
    run_burst(19'h00200, 8, 5'd9, 0, -1, 1);
    run_burst(19'h00300, 8, 5'd0, 0, 2, 0);
    run_burst(19'h00010, 4, 5'd0, 0, -1, 0);
    run_burst(19'h7FFFF, 2, 5'd1, 0, -1, 0);
    run_burst(19'h00040, 0, 5'd0, 0, -1, 0);
    run_burst(19'h00050, 1, 5'd31, 2, -1, 0);
    for (int t = 0; t < 12; t++)
      run_burst(19'($urandom), int'($urandom_range(1, 16)), 5'($urandom_range(0, 31)),
                2, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
